// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add MUL controller beside the single-cycle EX-stage ALU.
// Freezes the pipeline while iterating, then pulses done_o with the low product.
module mul_sequencer #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [3:0]      aluctr_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [3:0] ALU_MUL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_result;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   w_pp;
    logic [XLEN-1:0]   w_acc_next;
    logic              w_start;
    logic              w_last;
    logic              w_stall;

    // A held reset must not let a pending MUL raise stall.
    assign w_start = valid_i & (aluctr_i == ALU_MUL) & ~flush_i & ~rst_i;
    assign w_last  = (r_count == CW'(N - 1));

    // Partial product of the multiplicand with the low multiplier bits.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
        w_acc_next = r_acc + w_pp;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_stall = 1'b1;
                    w_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    w_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (w_last) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result latch on entering DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_start) begin
                r_mcand  <= src1_i;
                r_mplier <= src2_i;
                r_acc    <= '0;
                r_count  <= '0;
            end
        end else if (r_state == ST_RUN && !flush_i) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                r_result <= w_acc_next;
            end
        end
    end

    assign stall_o  = w_stall;
    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = (r_state == ST_DONE);
    assign result_o = r_result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases plus random
// operands against a plain-arithmetic product and latency model.
module tb_mul_sequencer;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        flush;
    logic [3:0]  aluctr;
    logic [31:0] src1;
    logic [31:0] src2;

    logic        stall1, busy1, done1;
    logic [31:0] res1;
    logic        stall4, busy4, done4;
    logic [31:0] res4;

    bit          sel;
    logic        w_stall, w_busy, w_done;
    logic [31:0] w_res;

    int n_checks;
    int n_fail;

    assign w_stall = sel ? stall4 : stall1;
    assign w_busy  = sel ? busy4  : busy1;
    assign w_done  = sel ? done4  : done1;
    assign w_res   = sel ? res4   : res1;

    mul_sequencer #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .aluctr_i(aluctr),
        .src1_i(src1), .src2_i(src2), .flush_i(flush),
        .stall_o(stall1), .busy_o(busy1), .done_o(done1), .result_o(res1)
    );

    mul_sequencer #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .aluctr_i(aluctr),
        .src1_i(src1), .src2_i(src2), .flush_i(flush),
        .stall_o(stall4), .busy_o(busy4), .done_o(done4), .result_o(res4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    // Present a MUL and check it is stalled on in the same cycle.
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid  = 1'b1;
        aluctr = 4'b1111;
        src1   = a;
        src2   = b;
        #1;
        check("start_stall", 32'(w_stall), 32'd1);
    endtask

    // From the accept cycle, follow the op to done_o and check it.
    task automatic finish(input logic [31:0] exp, input int lat,
                          input bit drop);
        int k;
        int bad;
        bad = 0;
        @(posedge clk);
        #1;
        if (drop) valid = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (w_done) break;
            if (!w_stall || !w_busy) bad++;
        end
        check("latency", 32'(k), 32'(lat));
        check("run_stall", 32'(bad), 32'd0);
        check("done_stall", 32'(w_stall), 32'd0);
        check("done_busy", 32'(w_busy), 32'd1);
        check("result", w_res, exp);
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b);
        accept(a, b);
        finish(ref_mul(a, b), 33, 1'b1);
    endtask

    initial begin
        logic [31:0] a, b, prev;
        int k;
        n_checks = 0;
        n_fail   = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        valid    = 1'b0;
        flush    = 1'b0;
        aluctr   = 4'b0000;
        src1     = '0;
        src2     = '0;
        #2;
        check("rst_stall", 32'(stall1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_result", res1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // T1 / T2 directed products
        do_mul(32'd7, 32'd6);
        check("t1_42", res1, 32'd42);
        do_mul(32'hFFFF_FFFD, 32'd5);
        check("t2_neg", res1, 32'hFFFF_FFF1);
        do_mul(32'h8000_0000, 32'd2);
        check("t2_wrap", res1, 32'd0);
        do_mul(32'd1234, 32'd0);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // T3 non-MUL codes never start
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid  = 1'b1;
            aluctr = (i == 0) ? 4'b0000 : (i == 1) ? 4'b1000 :
                     (i == 2) ? 4'b1101 : 4'($urandom_range(0, 14));
            src1   = $urandom;
            src2   = $urandom;
            #1;
            check("t3_stall", 32'(stall1), 32'd0);
            @(negedge clk);
            check("t3_busy", 32'(busy1), 32'd0);
            check("t3_done", 32'(done1), 32'd0);
        end
        valid = 1'b0;

        // flush in IDLE blocks start
        @(negedge clk);
        valid  = 1'b1;
        aluctr = 4'b1111;
        flush  = 1'b1;
        #1;
        check("idle_flush_stall", 32'(stall1), 32'd0);
        @(negedge clk);
        check("idle_flush_busy", 32'(busy1), 32'd0);
        valid = 1'b0;
        flush = 1'b0;

        // T4 flush in RUN cycle 10
        prev = res1;
        accept(32'd3, 32'd4);
        @(posedge clk);
        #1 valid = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("t4_flush_stall", 32'(stall1), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1 || busy1) k++;
        end
        check("t4_no_done", 32'(k), 32'd0);
        check("t4_hold", res1, prev);
        do_mul(32'd2, 32'd9);
        check("t4_18", res1, 32'd18);

        // T5 asynchronous reset mid-RUN
        accept(32'd11, 32'd13);
        @(posedge clk);
        #1 valid = 1'b0;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t5_stall", 32'(stall1), 32'd0);
        check("t5_busy", 32'(busy1), 32'd0);
        check("t5_result", res1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_mul(32'd5, 32'd5);
        check("t5_25", res1, 32'd25);

        // random operands
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 0) ? 32'd0 : $urandom;
            do_mul(a, b);
        end

        // T6 four bits per cycle, back-to-back with valid held
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        accept(32'h1234_5678, 32'h10);
        finish(32'h2345_6780, 9, 1'b0);
        src1 = 32'hFFFF;
        src2 = 32'hFFFF;
        @(negedge clk);
        #1;
        check("t6_idle_busy", 32'(busy4), 32'd0);
        check("t6_idle_stall", 32'(stall4), 32'd1);
        finish(32'hFFFE_0001, 9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            accept(a, b);
            finish(ref_mul(a, b), 9, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
